// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder
// ----------------------------------------------------------------------------
// Bit-serial adder/subtractor. One operand bit pair is processed per clock,
// LSB first, so a WIDTH-bit operation takes WIDTH cycles in RUN followed by a
// single DONE cycle. Subtraction is performed as in1 + ~in2 + 1, so the final
// carry doubles as a "no borrow" flag (1 means in1 >= in2, unsigned).
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request a new operation (ignored while busy)
//   sub    in   1      0 = add, 1 = subtract (in1 - in2); sampled with start
//   cin    in   1      carry-in for add; ignored for subtract
//   in1    in   WIDTH  operand A; sampled with start
//   in2    in   WIDTH  operand B; sampled with start
//   sum    out  WIDTH  result register (valid in DONE, held in IDLE)
//   carry  out  1      final carry-out (add) / no-borrow flag (subtract)
//   busy   out  1      operation in progress
//   done   out  1      one-cycle pulse, sum and carry valid
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    // Counter is one bit wider than needed to index WIDTH bits so that it
    // can reach WIDTH at the end of an operation without wrapping.
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q,   cnt_d;

    // Full adder built from two half-adder stages plus an OR.
    logic bit_p;
    logic bit_s;
    logic bit_c;

    always_comb begin
        bit_p = a_q[0] ^ b_q[0];
        bit_s = bit_p ^ carry_q;
        bit_c = (a_q[0] & b_q[0]) | (bit_p & carry_q);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;

        case (state_q)
            // IDLE and DONE both accept a new request; DONE -> RUN gives
            // back-to-back operation without passing through IDLE.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = in1;
                    b_d     = sub ? ~in2 : in2;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                sum_d   = {bit_s, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = bit_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sum   = sum_q;
    assign carry = carry_q;
    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic       cin;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [7:0] sum;
    logic       carry;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .in1   (in1),
        .in2   (in2),
        .sum   (sum),
        .carry (carry),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic       c;
        logic [7:0] exp_sum;
        logic       exp_carry;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation from IDLE, scramble inputs after acceptance, count
    // busy cycles and capture the result on the done cycle.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c,
                         output logic [7:0] rs, output logic rc, output int busy_cycles,
                         output bit got_done);
        @(negedge clk);
        start = 1'b1; in1 = a; in2 = b; sub = s; cin = c;
        @(negedge clk);
        start = 1'b0;
        in1 = 8'($urandom); in2 = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        busy_cycles = 0;
        got_done = 1'b0;
        rs = '0;
        rc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got_done = 1'b1;
                rs = sum;
                rc = carry;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    logic [7:0] rs;
    logic       rc;
    int         bc;
    bit         gd;
    int         seen_done;

    initial begin
        vecs[0] = '{8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{8'h10, 8'h01, 1'b1, 1'b0, 8'h0F, 1'b1};
        vecs[4] = '{8'h01, 8'h02, 1'b1, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1};
        vecs[7] = '{8'h80, 8'h80, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[8] = '{8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0};
        vecs[9] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1};

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; in1 = '0; in2 = '0;
        #3;
        check("reset_sum",   64'(sum),   64'h0);
        check("reset_carry", 64'(carry), 64'h0);
        check("reset_busy",  64'(busy),  64'h0);
        check("reset_done",  64'(done),  64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven operations
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, rs, rc, bc, gd);
            check($sformatf("v%0d_done", i),  64'(gd), 64'h1);
            check($sformatf("v%0d_busy", i),  64'(bc), 64'd8);
            check($sformatf("v%0d_sum", i),   64'(rs), 64'(vecs[i].exp_sum));
            check($sformatf("v%0d_carry", i), 64'(rc), 64'(vecs[i].exp_carry));
            @(negedge clk);
            check($sformatf("v%0d_pulse", i), 64'(done), 64'h0);
            check($sformatf("v%0d_idle", i),  64'(busy), 64'h0);
            @(negedge clk);
            check($sformatf("v%0d_hold", i),  64'({carry, sum}), 64'({vecs[i].exp_carry, vecs[i].exp_sum}));
        end

        // start while busy is ignored
        @(negedge clk);
        start = 1'b1; in1 = 8'h03; in2 = 8'h04; sub = 1'b0; cin = 1'b0;
        @(negedge clk);                 // after E0
        start = 1'b0;
        @(negedge clk);                 // after E0+1
        @(negedge clk);                 // after E0+2
        start = 1'b1; in1 = 8'hF0; in2 = 8'hF0;
        @(negedge clk);                 // after E0+3
        start = 1'b0;
        gd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin gd = 1'b1; break; end
            @(negedge clk);
        end
        check("ign_done",  64'(gd),    64'h1);
        check("ign_sum",   64'(sum),   64'h07);
        check("ign_carry", 64'(carry), 64'h0);
        @(negedge clk);
        check("ign_nobusy", 64'(busy), 64'h0);

        // Back-to-back: second op accepted on the edge ending the done cycle
        @(negedge clk);
        start = 1'b1; in1 = 8'h03; in2 = 8'h04; sub = 1'b0; cin = 1'b0;
        @(negedge clk);                 // after E0
        start = 1'b0;
        repeat (7) @(negedge clk);      // after E0+7
        check("b2b_busy7", 64'(busy), 64'h1);
        @(negedge clk);                 // after E0+8
        check("b2b_done1", 64'(done), 64'h1);
        check("b2b_sum1",  64'(sum),  64'h07);
        start = 1'b1; in1 = 8'h80; in2 = 8'h80;
        @(negedge clk);                 // after E0+9
        start = 1'b0;
        check("b2b_busy2", 64'(busy), 64'h1);
        repeat (7) @(negedge clk);      // after E0+16
        check("b2b_notyet", 64'(done), 64'h0);
        @(negedge clk);                 // after E0+17
        check("b2b_done2", 64'(done),  64'h1);
        check("b2b_sum2",  64'(sum),   64'h00);
        check("b2b_carry2", 64'(carry), 64'h1);

        // Reset mid-run aborts with no done pulse
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; in1 = 8'hA5; in2 = 8'h5A; sub = 1'b0; cin = 1'b1;
        @(posedge clk);                 // E0
        #1 start = 1'b0;
        repeat (4) @(posedge clk);      // E0+4
        #2 rst_n = 1'b0;
        #1;
        check("abort_sum",   64'(sum),   64'h0);
        check("abort_carry", 64'(carry), 64'h0);
        check("abort_busy",  64'(busy),  64'h0);
        check("abort_done",  64'(done),  64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        check("abort_nodone", 64'(seen_done), 64'h0);
        do_op(8'h01, 8'h01, 1'b0, 1'b0, rs, rc, bc, gd);
        check("post_done",  64'(gd), 64'h1);
        check("post_sum",   64'(rs), 64'h02);
        check("post_carry", 64'(rc), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
